// File: rtl/hold_until_eot_if.sv
// hold_until_eot_if: valid/ready/data handshake channel.
interface hold_until_eot_if #(parameter int W = 16);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;
   modport master (output valid, data, input ready);
   modport slave (input valid, data, output ready);
endinterface

// File: rtl/hold_until_eot.sv
// hold_until_eot: buffers a frame until its eot beat (or until the buffer fills),
// then replays it and issues a one-beat {eot, count} token for a release gate.
module hold_until_eot #(
   parameter int W_DIN  = 16,
   parameter int DEPTH  = 16,
   parameter int W_DONE = 16
) (
   input  logic             clk,
   input  logic             rst,
   hold_until_eot_if.slave  din,
   hold_until_eot_if.master dout,
   hold_until_eot_if.master done
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam int CW = W_DONE - 1;
   typedef enum logic [1:0] {S_FILL, S_DRAIN, S_STREAM, S_DONE} state_t;
   state_t           r_state, w_next;
   logic [W_DIN-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [OW-1:0]    r_occ;
   logic [CW-1:0]    r_cnt;
   logic             r_eot_in;
   logic             w_full, w_empty, w_wr, w_rd;
   assign w_full  = r_occ == OW'(DEPTH);
   assign w_empty = r_occ == '0;
   assign w_wr    = din.valid && din.ready;
   assign w_rd    = dout.valid && dout.ready;
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FILL;
      else     r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FILL:
            if (w_wr) w_next = din.data[W_DIN-1] ? S_DRAIN : (r_occ == OW'(DEPTH-1)) ? S_STREAM : S_FILL;
         S_DRAIN, S_STREAM:
            if (w_rd && dout.data[W_DIN-1]) w_next = S_DONE;
         default:
            if (done.ready) w_next = S_FILL;
      endcase
   end
   // valids depend only on state and occupancy, never on a ready input
   always_comb begin
      din.ready  = (r_state == S_FILL) ? !w_full : (r_state == S_STREAM) ? (!w_full && !r_eot_in) : 1'b0;
      dout.valid = (r_state == S_DRAIN || r_state == S_STREAM) && !w_empty;
      dout.data  = r_mem[r_rd_ptr];
      done.valid = r_state == S_DONE;
      done.data  = {1'b1, r_cnt};
   end
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= din.data;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_cnt    <= '0;
         r_eot_in <= 1'b0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_occ <= r_occ + OW'(w_wr) - OW'(w_rd);
         if (r_state == S_DONE && done.ready) r_cnt <= '0;
         else if (w_wr && !(&r_cnt)) r_cnt <= r_cnt + CW'(1);
         if (r_state == S_DONE) r_eot_in <= 1'b0;
         else if (w_wr && din.data[W_DIN-1]) r_eot_in <= 1'b1;
      end
   end
endmodule
